sum_prod_seq: RTL and testbench
===============================

SUM_PROD_SEQ -- requirements
Module: sum_prod_seq

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: request a new computation.
REQ-005 SHALL have port X, input, unpacked array [5:0] of N bits: operands, unsigned.
REQ-006 SHALL have port busy, output, 1 bit: computation in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse marking a new result.
REQ-008 SHALL have port result, output, 2N+3 bits: X0*X1 + X2*X3 + X4*X5 of the captured operands.

Function
REQ-009 SHALL use exactly one N x N multiplier, time-shared across the three products; no second multiplier instance.
REQ-010 SHALL implement FSM states IDLE, MUL, DONE.
REQ-011 SHALL accept start only in IDLE or DONE; on acceptance, capture all six X into operand registers, clear the accumulator, set pair index to 0, and go to MUL.
REQ-012 SHALL ignore start while in MUL; captured operands stay unchanged, and X changes after capture have no effect.
REQ-013 SHALL, in MUL, add product Xr[2i]*Xr[2i+1] (zero-extended to 2N+3 bits) to the accumulator each cycle, for i = 0, 1, 2.
REQ-014 SHALL, after the i = 2 accumulate, load result from the accumulator and go to DONE; the index does not advance beyond 2.
REQ-015 SHALL assert done in DONE only, exactly one cycle per computation; DONE goes to IDLE, or to MUL if start is accepted.
REQ-016 SHALL have latency: start sampled high at edge t gives result valid and done high from edge t+3 to edge t+4.
REQ-017 SHALL keep result stable from edge t+3 until the next computation's result load.
REQ-018 SHALL assert busy iff the state is MUL.
REQ-019 SHALL never overflow: max 3*(2^N-1)^2 fits in 2N+3 bits; no saturation logic.
REQ-020 SHALL sustain one result per 4 cycles with start held high continuously.

Reset
REQ-021 SHALL, with rst_n low, immediately force: state IDLE, busy 0, done 0, result 0, accumulator 0, operand registers 0, index 0.
REQ-022 SHALL, on reset asserted mid-computation, discard the computation; no done follows reset release.
REQ-023 SHALL treat start as a normal request from the first rising edge with rst_n high.

Configuration
REQ-024 SHALL, with macro SUM_PROD_SEQ_ABORT_EN defined, add input port abort (1 bit); abort high at an edge in MUL goes to IDLE, suppresses done, and leaves result unchanged.
REQ-025 SHALL, with SUM_PROD_SEQ_ABORT_EN defined, give abort priority over start at the same edge and have no effect in IDLE or DONE.
REQ-026 SHALL, without SUM_PROD_SEQ_ABORT_EN, have no abort port and no abort logic.

Verification (N=4)
REQ-027 X={2,3,1,4,0,5}, start pulse at edge t -> busy edges t+1..t+3, done high for exactly one cycle after edge t+3, result=10.
REQ-028 X={7,8,2,3,1,1}, start; X changed to all 0 at edge t+1 -> result=63.
REQ-029 X all 15, start held high for 8 cycles -> result=675, with done pulses 4 cycles apart.
REQ-030 Start pulse, then rst_n low at edge t+2 and released -> result=0, done never asserted, state IDLE.
REQ-031 With SUM_PROD_SEQ_ABORT_EN: run X={2,3,1,4,0,5} to result 10, then X all 15 with abort at edge t+2 -> no done, result stays 10; abort and start together in MUL -> IDLE.

Source files
------------

// File: rtl/sum_prod_seq.sv
// sum_prod_seq: sequential X0*X1 + X2*X3 + X4*X5 using one shared N x N multiplier.
// Operands are captured on start; three accumulate cycles follow, then a one-cycle done.
// Optional feature: define SUM_PROD_SEQ_ABORT_EN to add an abort input that cancels
// a computation in progress.
//
// state | meaning
// IDLE  | waiting for start, result holds last value
// MUL   | accumulating one operand-pair product per cycle (busy)
// DONE  | result freshly loaded, done pulses for this single cycle
module sum_prod_seq #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SUM_PROD_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic [N-1:0]     X [5:0],
    output logic             busy,
    output logic             done,
    output logic [2*N+2:0]   result
);

    localparam int W = 2 * N + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   ops [5:0];
    logic [1:0]     idx;
    logic [W-1:0]   acc;

    logic [N-1:0]   mul_a;
    logic [N-1:0]   mul_b;
    logic [2*N-1:0] prod;
    logic [W-1:0]   acc_sum;

    // Select the operand pair for the current index; the single multiplier is shared.
    always_comb begin
        mul_a = ops[0];
        mul_b = ops[1];
        case (idx)
            2'd1: begin
                mul_a = ops[2];
                mul_b = ops[3];
            end
            2'd2: begin
                mul_a = ops[4];
                mul_b = ops[5];
            end
            default: begin
                mul_a = ops[0];
                mul_b = ops[1];
            end
        endcase
    end

    assign prod    = mul_a * mul_b;
    assign acc_sum = acc + {3'b000, prod};

    // Control FSM with registered busy/done and the datapath registers it owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
            idx    <= 2'd0;
            for (int k = 0; k < 6; k++) begin
                ops[k] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int k = 0; k < 6; k++) begin
                            ops[k] <= X[k];
                        end
                        acc   <= '0;
                        idx   <= 2'd0;
                        state <= MUL;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                MUL: begin
`ifdef SUM_PROD_SEQ_ABORT_EN
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else
`endif
                    begin
                        acc <= acc_sum;
                        if (idx == 2'd2) begin
                            // Final pair: publish the completed sum in the same edge.
                            result <= acc_sum;
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_prod_seq.sv
// Testbench for sum_prod_seq (N=4): directed scenarios plus randomized traffic,
// compared each cycle against a transaction-level reference model.
module tb_sum_prod_seq;

    localparam int N = 4;
    localparam int W = 2 * N + 3;
`ifdef SUM_PROD_SEQ_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           abort;
    logic [N-1:0]   X [5:0];
    logic           busy;
    logic           done;
    logic [W-1:0]   result;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: remaining accumulate cycles, pending sum, visible result/done.
    int m_left    = 0;
    int m_pending = 0;
    int m_result  = 0;
    bit m_done    = 1'b0;

    sum_prod_seq #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
`ifdef SUM_PROD_SEQ_ABORT_EN
        .abort  (abort),
`endif
        .X      (X),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int ref_sum();
        int s = 0;
        for (int p = 0; p < 3; p++) begin
            s += int'(X[2*p]) * int'(X[2*p+1]);
        end
        return s;
    endfunction

    task automatic set_x(input int a, input int b, input int c, input int d, input int e, input int f);
        X[0] = N'(a); X[1] = N'(b); X[2] = N'(c);
        X[3] = N'(d); X[4] = N'(e); X[5] = N'(f);
    endtask

    task automatic model_reset();
        m_left    = 0;
        m_pending = 0;
        m_result  = 0;
        m_done    = 1'b0;
    endtask

    // Advance model by one clock using the inputs as they will be sampled, then compare.
    task automatic step();
        if (m_left > 0) begin
            if (ABORT_EN && abort) begin
                m_left = 0;
                m_done = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_result = m_pending;
                    m_done   = 1'b1;
                end
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_pending = ref_sum();
                m_left    = 3;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("result", 32'(result), 32'(m_result));
    endtask

    initial begin
        int d1;
        int d2;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_x(0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", 32'(result), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic computation: 2*3 + 1*4 + 0*5 = 10
        set_x(2, 3, 1, 4, 0, 5);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("r027_done", {31'd0, done}, 32'd1);
        check("r027_result", 32'(result), 32'd10);
        step();
        check("r027_done_once", {31'd0, done}, 32'd0);

        // Operands change right after capture: 7*8 + 2*3 + 1*1 = 63
        set_x(7, 8, 2, 3, 1, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        set_x(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        check("r028_result", 32'(result), 32'd63);
        step();

        // Start held high: back-to-back results every 4 cycles
        set_x(15, 15, 15, 15, 15, 15);
        start = 1'b1;
        d1 = -1;
        d2 = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) begin
                if (d1 < 0) d1 = cyc;
                else if (d2 < 0) d2 = cyc;
            end
        end
        start = 1'b0;
        check("r029_result", 32'(result), 32'd675);
        check("r029_gap", 32'(d2 - d1), 32'd4);
        step();
        step();

        // Reset mid-computation discards the run
        set_x(3, 3, 3, 3, 3, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("r030_busy", {31'd0, busy}, 32'd0);
        check("r030_done", {31'd0, done}, 32'd0);
        check("r030_result", 32'(result), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();

`ifdef SUM_PROD_SEQ_ABORT_EN
        set_x(2, 3, 1, 4, 0, 5);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("r031_first", 32'(result), 32'd10);
        set_x(15, 15, 15, 15, 15, 15);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("r031_kept", 32'(result), 32'd10);
        start = 1'b1;
        step();
        abort = 1'b1;
        step();
        check("r031_both_idle", {31'd0, busy}, 32'd0);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 4; i++) step();
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 2) == 0);
            abort = ABORT_EN && ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 6; k++) X[k] = N'($urandom_range(0, (1 << N) - 1));
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 5; i++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
